// File: rtl/taxi_axis_mux_arb_if.sv
// Control/tap bundle between taxi_axis_mux_arb and the AXI4-Stream mux it steers.
// The timeout_pulse signal exists only when TAXI_AXIS_MUX_ARB_TIMEOUT_EN is defined.
interface taxi_axis_mux_arb_if #(
    parameter int S_COUNT = 4
);
    localparam int SEL_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    logic               arb_en;
    logic [S_COUNT-1:0] s_tvalid;
    logic [S_COUNT-1:0] s_tready;
    logic [S_COUNT-1:0] s_tlast;
    logic               enable;
    logic [SEL_W-1:0]   select;
    logic               busy;
    logic [SEL_W-1:0]   grant_idx;
`ifdef TAXI_AXIS_MUX_ARB_TIMEOUT_EN
    logic               timeout_pulse;

    modport master (
        input  arb_en, s_tvalid, s_tready, s_tlast,
        output enable, select, busy, grant_idx, timeout_pulse
    );
    modport slave (
        output arb_en, s_tvalid, s_tready, s_tlast,
        input  enable, select, busy, grant_idx, timeout_pulse
    );
`else
    modport master (
        input  arb_en, s_tvalid, s_tready, s_tlast,
        output enable, select, busy, grant_idx
    );
    modport slave (
        output arb_en, s_tvalid, s_tready, s_tlast,
        input  enable, select, busy, grant_idx
    );
`endif
endinterface

// File: rtl/taxi_axis_mux_arb.sv
// Frame-level arbiter steering an AXI4-Stream mux: grant held from selection until the tlast beat.
// Optional ARMED-state abandon timer enabled by defining TAXI_AXIS_MUX_ARB_TIMEOUT_EN.
module taxi_axis_mux_arb #(
    parameter int S_COUNT         = 4,
    parameter int ARB_ROUND_ROBIN = 1,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    taxi_axis_mux_arb_if.master  io_arb
);
    localparam int SEL_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_enable;
    logic [SEL_W-1:0]   r_select;
    logic [SEL_W-1:0]   r_grant_idx;
    logic [SEL_W-1:0]   r_ptr;

    logic [S_COUNT-1:0] w_req;
    logic               w_req_any;
    logic [SEL_W-1:0]   w_win;
    logic [SEL_W-1:0]   w_rr_idx;
    logic               w_sel_hs;
    logic               w_sel_last;
    logic               w_grant;
    logic               w_tmo_hit;

    assign w_req      = io_arb.s_tvalid;
    assign w_req_any  = |w_req;
    // Only the selected port's handshake matters; everything else on the taps is ignored.
    assign w_sel_hs   = io_arb.s_tvalid[r_select] && io_arb.s_tready[r_select];
    assign w_sel_last = w_sel_hs && io_arb.s_tlast[r_select];

    // Scan from the far end so the closest candidate is written last and wins.
    always_comb begin
        w_win    = '0;
        w_rr_idx = '0;
        if (ARB_ROUND_ROBIN != 0) begin
            for (int i = S_COUNT; i >= 1; i--) begin
                w_rr_idx = SEL_W'((int'(r_ptr) + i) % S_COUNT);
                if (w_req[w_rr_idx]) w_win = w_rr_idx;
            end
        end else begin
            for (int i = S_COUNT - 1; i >= 0; i--) begin
                if (w_req[SEL_W'(i)]) w_win = SEL_W'(i);
            end
        end
    end

`ifdef TAXI_AXIS_MUX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_pulse;

    assign w_tmo_hit = (r_state == ST_ARMED) && !w_sel_hs &&
                       (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt   <= '0;
            r_tmo_pulse <= 1'b0;
        end else begin
            r_tmo_pulse <= w_tmo_hit;
            if (r_state != ST_ARMED) r_tmo_cnt <= '0;
            else if (!w_sel_hs)      r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    assign io_arb.timeout_pulse = r_tmo_pulse;
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_arb.arb_en && w_req_any) begin
                    w_state_nxt = ST_ARMED;
                    w_grant     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (w_sel_hs)       w_state_nxt = io_arb.s_tlast[r_select] ? ST_DONE : ST_BUSY;
                else if (w_tmo_hit) w_state_nxt = ST_DONE;
            end
            ST_BUSY: begin
                if (w_sel_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // enable drops on the tlast edge itself so the mux cannot re-latch the same port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_enable    <= 1'b0;
            r_select    <= '0;
            r_grant_idx <= '0;
            r_ptr       <= SEL_W'(S_COUNT - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_enable <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_BUSY);
            if (w_grant) begin
                r_select    <= w_win;
                r_grant_idx <= w_win;
            end
            if (r_state == ST_DONE) r_ptr <= r_select;
        end
    end

    assign io_arb.enable    = r_enable;
    assign io_arb.select    = r_select;
    assign io_arb.grant_idx = r_grant_idx;
    assign io_arb.busy      = (r_state == ST_ARMED) || (r_state == ST_BUSY);

endmodule
